// File: rtl/muldiv_defines.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 operation
// codes, the OP-instruction funct7 used by decode, FSM state encoding and
// the default datapath width.
package muldiv_defines;

  localparam int MD_XLEN = 32;

  // funct7 that selects the M extension within OP instructions
  localparam logic [6:0] MD_FUNCT7 = 7'b0000001;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // funct3[2] separates the divide group from the multiply group
  function automatic logic md_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration. The partial remainder is shifted left
// by one, taking in the next dividend bit from the quotient register's MSB;
// the XLEN+1-bit shifted value is compared with the divisor and the
// divisor is subtracted when it fits, shifting the outcome into the quotient.
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] rem_sh;
  logic          fits;

  // Shift, trial-compare and restore in a single combinational step
  always_comb begin
    rem_sh = {rem_i, quo_i[XLEN-1]};
    fits   = (rem_sh >= {1'b0, dvsr_i});
    // When the divisor fits the difference is below the divisor, so the
    // low XLEN bits of the subtraction are exact.
    rem_o  = fits ? (rem_sh[XLEN-1:0] - dvsr_i) : rem_sh[XLEN-1:0];
    quo_o  = {quo_i[XLEN-2:0], fits};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a start/done handshake.
// Multiply: 32-cycle shift-add on operand magnitudes with a sign fix-up.
// Divide: 32-cycle restoring division on magnitudes with a sign fix-up;
// divide-by-zero and signed overflow finish in the start cycle.
// Build option: MULDIV_FAST_MUL_EN routes all multiplies through a single
// combinational signed multiply that completes in the start cycle.
module muldiv_unit
  import muldiv_defines::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = 6
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_start,
  input  logic            i_kill,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  logic [XLEN-1:0]     op_b_q, op_b_d;     // multiplicand / divisor magnitude
  logic [2*XLEN-1:0]   acc_q, acc_d;       // product; low half is quotient for divide
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Start-cycle operand decode
  logic                rs1_signed, rs2_signed;
  logic                sa, sb;
  logic [XLEN-1:0]     abs_a, abs_b;
  logic                div_zero, div_ovf, special;
  logic [XLEN-1:0]     special_res;

  // Iteration and final-result datapath
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_acc_nxt;
  logic [XLEN-1:0]     div_rem_nxt, div_quo_nxt;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix, final_res;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0]   fast_a, fast_b, fast_prod;
  logic [XLEN-1:0]     fast_res;
`endif

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i  (rem_q),
    .quo_i  (acc_q[XLEN-1:0]),
    .dvsr_i (op_b_q),
    .rem_o  (div_rem_nxt),
    .quo_o  (div_quo_nxt)
  );

  // Decode operand signedness and special divide cases from the live inputs
  always_comb begin
    rs1_signed  = (i_funct3 == MD_MULH) || (i_funct3 == MD_MULHSU) ||
                  (i_funct3 == MD_DIV)  || (i_funct3 == MD_REM);
    rs2_signed  = (i_funct3 == MD_MULH) || (i_funct3 == MD_DIV) ||
                  (i_funct3 == MD_REM);
    sa          = rs1_signed & i_rs1[XLEN-1];
    sb          = rs2_signed & i_rs2[XLEN-1];
    abs_a       = sa ? -i_rs1 : i_rs1;
    abs_b       = sb ? -i_rs2 : i_rs2;
    div_zero    = (i_rs2 == '0);
    div_ovf     = ((i_funct3 == MD_DIV) || (i_funct3 == MD_REM)) &&
                  (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&i_rs2);
    special     = md_is_div(i_funct3) && (div_zero || div_ovf);
    // funct3[1] marks the remainder variants
    if (div_zero)
      special_res = i_funct3[1] ? i_rs1 : '1;
    else
      special_res = i_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

`ifdef MULDIV_FAST_MUL_EN
  // Single XLEN+1 x XLEN+1 signed multiply, evaluated modulo 2^(2*XLEN)
  always_comb begin
    fast_a    = {{(XLEN-1){sa}}, sa, i_rs1};
    fast_b    = {{(XLEN-1){sb}}, sb, i_rs2};
    fast_prod = fast_a * fast_b;
    fast_res  = (i_funct3 == MD_MUL) ? fast_prod[XLEN-1:0]
                                     : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  // Shift-add multiply step and sign-corrected result of the final iteration
  always_comb begin
    mul_sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op_b_q} : '0);
    mul_acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
    prod_fix    = (sign_a_q ^ sign_b_q) ? -mul_acc_nxt : mul_acc_nxt;
    quo_fix     = (sign_a_q ^ sign_b_q) ? -div_quo_nxt : div_quo_nxt;
    rem_fix     = sign_a_q ? -div_rem_nxt : div_rem_nxt;
    case (f3_q)
      MD_MUL:                      final_res = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             final_res = quo_fix;
      default:                     final_res = rem_fix;
    endcase
  end

  // Control FSM and next-state for all datapath registers
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    op_b_d   = op_b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_kill) begin
          f3_d     = i_funct3;
          sign_a_d = sa;
          sign_b_d = sb;
          op_b_d   = abs_b;
          acc_d    = {{XLEN{1'b0}}, abs_a};
          rem_d    = '0;
          cnt_d    = CNT_W'(XLEN);
          if (special) begin
            result_d = special_res;
            state_d  = ST_DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!md_is_div(i_funct3)) begin
            result_d = fast_res;
            state_d  = ST_DONE;
`endif
          end else begin
            state_d  = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q - 1'b1;
        if (md_is_div(f3_q)) begin
          acc_d = {acc_q[2*XLEN-1:XLEN], div_quo_nxt};
          rem_d = div_rem_nxt;
        end else begin
          acc_d = mul_acc_nxt;
        end
        if (cnt_q == CNT_W'(1)) begin
          result_d = final_res;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A flush abandons the operation and leaves the last result visible
    if (i_kill) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      op_b_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      op_b_q   <= op_b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign o_busy   = (state_q != ST_IDLE);
  assign o_done   = (state_q == ST_DONE);
  assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit with hand-computed expected results.
// Expected multiply latency follows MULDIV_FAST_MUL_EN when it is defined.
module tb_muldiv_unit;
  import muldiv_defines::*;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_start;
  logic        i_kill;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;

  int total = 0;
  int bad   = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int SPC_LAT = 1;

  muldiv_unit dut (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_start  (i_start),
    .i_kill   (i_kill),
    .i_funct3 (i_funct3),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Junk inputs that would visibly start a one-cycle DIVU-by-zero if accepted
  task automatic drive_junk();
    i_funct3 = MD_DIVU;
    i_rs1    = 32'h0000_0000;
    i_rs2    = 32'h0000_0000;
  endtask

  // Launch one operation, wait for o_done (bounded), check result and timing
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat,
                        input bit pulse_calc, input bit pulse_done);
    int cycles;
    bit busy_low;
    i_funct3 = f3;
    i_rs1    = a;
    i_rs2    = b;
    i_start  = 1'b1;
    @(posedge i_clk); #1;
    i_start  = 1'b0;
    drive_junk();
    cycles   = 1;
    busy_low = 1'b0;
    while (!o_done && cycles < 100) begin
      if (!o_busy) busy_low = 1'b1;
      i_start = (pulse_calc && cycles == 5);
      @(posedge i_clk); #1;
      cycles++;
    end
    i_start = 1'b0;
    $display("op %s f3=%0d rs1=0x%08h rs2=0x%08h result=0x%08h lat=%0d", tag, f3, a, b, o_result, cycles);
    check_eq({tag, "_done"}, 32'(o_done), 32'd1);
    check_eq({tag, "_lat"}, 32'(cycles), 32'(exp_lat));
    check_eq({tag, "_res"}, o_result, exp_res);
    check_eq({tag, "_busy"}, 32'(busy_low), 32'd0);
    check_eq({tag, "_busy_at_done"}, 32'(o_busy), 32'd1);
    if (pulse_done) i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    check_eq({tag, "_done_clr"}, 32'(o_done), 32'd0);
    check_eq({tag, "_idle"}, 32'(o_busy), 32'd0);
    check_eq({tag, "_hold"}, o_result, exp_res);
  endtask

  initial begin
    int done_seen;
    i_rstn   = 1'b0;
    i_start  = 1'b0;
    i_kill   = 1'b0;
    i_funct3 = 3'b000;
    i_rs1    = '0;
    i_rs2    = '0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    @(posedge i_clk); #1;
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_done", 32'(o_done), 32'd0);
    check_eq("rst_result", o_result, 32'd0);

    // Multiply
    run_op("mulh_min",   MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 0, 0);
    run_op("mulhsu_m1",  MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 0, 0);
    run_op("mul_m1",     MD_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT, 0, 0);
    run_op("mulhu_m1",   MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 0, 0);
    run_op("mul_7xm3",   MD_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 0, 0);
    run_op("mulh_7xm3",  MD_MULH,   32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, MUL_LAT, 0, 0);

    // Divide
    run_op("div_7_m2",   MD_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT, 0, 0);
    run_op("rem_7_m2",   MD_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, DIV_LAT, 0, 0);
    run_op("div_m7_2",   MD_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT, 0, 0);
    run_op("rem_m7_2",   MD_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT, 0, 0);
    run_op("divu_100_7", MD_DIVU,   32'd100,       32'd7,         32'd14,        DIV_LAT, 0, 0);
    run_op("remu_100_7", MD_REMU,   32'd100,       32'd7,         32'd2,         DIV_LAT, 0, 0);
    run_op("divu_big",   MD_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, DIV_LAT, 0, 0);
    run_op("remu_big",   MD_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT, 0, 0);

    // Special divide cases finish in the start cycle
    run_op("divu_z",     MD_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, SPC_LAT, 0, 0);
    run_op("remu_z",     MD_REMU,   32'd5,         32'd0,         32'd5,         SPC_LAT, 0, 0);
    run_op("div_z",      MD_DIV,    32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFFF, SPC_LAT, 0, 0);
    run_op("div_ovf",    MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT, 0, 0);
    run_op("rem_ovf",    MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPC_LAT, 0, 0);

    // Start pulses during CALC and during DONE are ignored
    run_op("divu_pulse", MD_DIVU,   32'd100,       32'd7,         32'd14,        DIV_LAT, 1, 1);

    // Kill at CALC cycle 10: prior result (14) must survive
    i_funct3 = MD_DIVU; i_rs1 = 32'hFFFF_FFFF; i_rs2 = 32'd3; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (9) begin @(posedge i_clk); #1; end
    check_eq("kill_pre_busy", 32'(o_busy), 32'd1);
    i_kill = 1'b1;
    @(posedge i_clk); #1;
    i_kill = 1'b0;
    $display("op kill_calc busy=%0d done=%0d result=0x%08h", o_busy, o_done, o_result);
    check_eq("kill_busy", 32'(o_busy), 32'd0);
    check_eq("kill_done", 32'(o_done), 32'd0);
    check_eq("kill_result", o_result, 32'd14);
    done_seen = 0;
    repeat (40) begin
      @(posedge i_clk); #1;
      if (o_done || o_busy) done_seen++;
    end
    check_eq("kill_no_done", 32'(done_seen), 32'd0);

    // Kill wins over a simultaneous start
    i_funct3 = MD_DIVU; i_rs1 = 32'd5; i_rs2 = 32'd0; i_start = 1'b1; i_kill = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_kill = 1'b0;
    $display("op kill_start busy=%0d result=0x%08h", o_busy, o_result);
    check_eq("kill_start_busy", 32'(o_busy), 32'd0);
    check_eq("kill_start_result", o_result, 32'd14);

    run_op("divu_9_3",   MD_DIVU,   32'd9,         32'd3,         32'd3,         DIV_LAT, 0, 0);

    // Asynchronous reset mid-CALC
    i_funct3 = MD_DIVU; i_rs1 = 32'd1000; i_rs2 = 32'd7; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (5) begin @(posedge i_clk); #1; end
    check_eq("arst_pre_busy", 32'(o_busy), 32'd1);
    i_rstn = 1'b0;
    #1;
    $display("op async_reset busy=%0d done=%0d result=0x%08h", o_busy, o_done, o_result);
    check_eq("arst_busy", 32'(o_busy), 32'd0);
    check_eq("arst_done", 32'(o_done), 32'd0);
    check_eq("arst_result", o_result, 32'd0);
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    @(posedge i_clk); #1;
    check_eq("arst_after_busy", 32'(o_busy), 32'd0);

    run_op("remu_after", MD_REMU,   32'd1000,      32'd7,         32'd6,         DIV_LAT, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit, sitting in the execute stage beside the ALU.
- Consumes the register operands and funct3 of OP instructions with funct7 = 0000001; the ALU does not execute these.
- Returns the 32-bit result to the writeback mux through a start/done handshake.
- Control stalls the pipeline while o_busy is high.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 6, width of the iteration counter; must hold XLEN.

Ports:
i_clk  in  1  clock, rising edge
i_rstn  in  1  asynchronous active-low reset
i_start  in  1  launch operation; sampled only in IDLE
i_kill  in  1  pipeline flush; aborts any operation in progress
i_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
i_rs1  in  XLEN  multiplicand / dividend
i_rs2  in  XLEN  multiplier / divisor
o_busy  out  1  high in CALC and DONE
o_done  out  1  single-cycle pulse; o_result valid
o_result  out  XLEN  result; held until the next accepted start

Behaviour:
- Reset: state IDLE; o_busy=0, o_done=0, o_result=0; counter, accumulator and operand registers all 0.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC on i_start & !i_kill: latch funct3 and operands; capture operand signs; load absolute values.
    - Signed ops: MULH both operands signed, MULHSU rs1 only, DIV/REM both. MUL uses unsigned magnitudes.
    - Counter loads XLEN.
  - IDLE -> DONE directly for special divide cases, with the result computed in the start cycle:
    - Divisor 0: DIV/DIVU = all ones; REM/REMU = rs1.
    - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): DIV = 0x80000000; REM = 0.
  - CALC: one iteration per cycle; counter decrements.
    - Multiply: shift-add into a 2*XLEN accumulator.
    - Divide: restoring step; remainder is XLEN+1 bits wide.
    - Counter==1 -> DONE. The last iteration and the sign fix-up/select are registered into o_result on that edge.
  - DONE: o_done=1 for exactly one cycle; then -> IDLE.
- Latency: start accepted at edge T. Normal ops give o_done high in cycle T+33 (32 CALC cycles). Special cases give o_done in cycle T+1.
- Result select:
  - MUL: low XLEN bits of the signed-corrected product.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - Sign fix: negate the 64-bit product if the operand signs differ; negate the quotient if the signs differ; remainder takes the dividend's sign.
- i_start outside IDLE is ignored; no queuing.
- i_kill in any state: next state IDLE, o_busy=0, o_done=0; o_result unchanged. i_kill wins over a simultaneous i_start.
- i_start in the DONE cycle is ignored; a new operation may start in the following IDLE cycle.
- Reset assertion mid-operation: immediate return to the reset values.
- Operand registers are isolated from inputs after acceptance; inputs may change freely.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: all multiply ops compute through a single combinational XLEN+1 x XLEN+1 signed multiply in the start cycle and go IDLE -> DONE, so o_done arrives in cycle T+1. Divide timing is unchanged.
- Undefined: multiply uses the 32-cycle shift-add path; no hardware multiplier is inferred.

Decomposition:
- Shared package/header muldiv_defines: funct3 codes (MD_MUL..MD_REMU), funct7 value 0000001 for decode, FSM state encoding, XLEN default.
- One sub-module: muldiv_div_step. Combinational restoring-divide iteration: remainder/quotient/divisor in, next remainder/quotient out.
- Multiply stays inline.

Test Plan:
- MULH 0x80000000 x 0x80000000 -> o_result=0x40000000; o_done at T+33 (T+1 with MULDIV_FAST_MUL_EN); o_busy high throughout.
- MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF; MUL same operands -> 0x00000001; MULHU -> 0xFFFFFFFE.
- DIV 7 / 0xFFFFFFFE (-2) -> 0xFFFFFFFD; REM same -> 0x00000001; DIVU 100/7 -> 14; REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0; each o_done at T+1.
- i_kill asserted at CALC cycle 10 -> o_busy=0 next cycle, no o_done, o_result keeps the prior value. A following DIVU 9/3 -> 3.
- i_start pulses during CALC and during DONE -> ignored; the in-flight result is unchanged. Async i_rstn low mid-CALC -> outputs 0 immediately.
